seg7_scan_rx: RTL and testbench
===============================

SEG7_SCAN_RX -- requirements
Module: seg7_scan_rx

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digit positions (range 1..8).
REQ-002 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical samples required before capture (range 2..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 seg_n  input  7  SHALL carry active-low segment lines, bit0=a … bit6=g.
REQ-006 dig_sel_n  input  NUM_DIGITS  SHALL carry active-low digit enables; bit i selects digit i.
REQ-007 bcd_out  output  4*NUM_DIGITS  SHALL hold the decoded value of digit i in bits [4i+3:4i].
REQ-008 digit_valid  output  NUM_DIGITS  SHALL flag that bcd_out slot i holds a decode from a legal pattern.
REQ-009 frame_done  output  1  SHALL be a one-cycle pulse marking a complete, fully valid scan frame.
REQ-010 pattern_err  output  1  SHALL be a one-cycle pulse on capture of an illegal pattern.
REQ-011 err_digit  output  3  SHALL hold the digit index of the most recent pattern_err.

Function
REQ-012 seg_n and dig_sel_n SHALL be registered once per cycle into sample registers; all decisions use the registered samples.
REQ-013 FSM states SHALL be IDLE, TRACK, HELD.
REQ-014 IDLE: a one-hot-low sample (exactly one dig_sel_n bit 0) SHALL move to TRACK with stable count 1.
REQ-015 TRACK: a sample equal to the previous sample SHALL increment the count; a differing one-hot sample SHALL restart the count at 1; a non-one-hot sample SHALL return to IDLE with count 0.
REQ-016 When the count reaches STABLE_CYCLES, the FSM SHALL capture exactly once and enter HELD; outputs update on that same edge.
REQ-017 HELD: an unchanged sample SHALL cause no further capture; a changed one-hot sample SHALL go to TRACK with count 1; a non-one-hot sample SHALL go to IDLE.
REQ-018 Legal digit patterns (seg_n, g..a) SHALL decode to: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Legal capture SHALL write the slot value and set digit_valid[i].
REQ-020 Blank pattern 1111111 SHALL clear digit_valid[i], leave the slot unchanged, and raise no error.
REQ-021 Any other pattern SHALL clear digit_valid[i], leave the slot unchanged, pulse pattern_err, and load err_digit=i.
REQ-022 frame_done SHALL pulse on the capture edge of digit NUM_DIGITS-1 if, after that capture, all digit_valid bits are 1.
REQ-023 Latency: pins held constant from before edge k SHALL produce the capture on edge k+STABLE_CYCLES.

Reset
REQ-024 rst SHALL force FSM=IDLE, count=0, sample registers to all ones, bcd_out=0, digit_valid=0, frame_done=0, pattern_err=0, err_digit=0.
REQ-025 rst mid-TRACK SHALL discard the partial run; no capture SHALL occur on the reset edge.

Configuration
REQ-026 With SEG7_HEX_EN defined, patterns A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 SHALL be legal and decode to 10..15.
REQ-027 Without SEG7_HEX_EN, those patterns SHALL be illegal per REQ-021.

Structure
REQ-028 Package seg7_pkg SHALL hold the segment pattern constants, the blank constant, the FSM state enum, and the count width.
REQ-029 A combinational sub-module seg7_pattern_decode SHALL map 7-bit patterns to {legal, blank, value[3:0]}; all sequencing stays in seg7_scan_rx.

Verification
REQ-030 Reset, then digit 0 with seg_n=0100100 held 4 cycles -> after capture edge bcd_out[3:0]=2 and digit_valid=0001.
REQ-031 Four-digit scan 1,2,3,4, each held 6 cycles -> one frame_done pulse, bcd_out=16'h4321, digit_valid=1111, no pattern_err.
REQ-032 Digit 2 with seg_n=0110110 held 4 cycles -> pattern_err single pulse, err_digit=2, digit_valid[2]=0, slot 2 unchanged.
REQ-033 Glitch: seg_n toggles after 3 stable cycles -> no capture; capture occurs 4 cycles after the last change.
REQ-034 dig_sel_n=1001 (two active) for 10 cycles -> no capture, FSM stays IDLE; then rst mid-TRACK -> all outputs 0.
REQ-035 seg_n=0001000: with SEG7_HEX_EN -> slot=4'hA; without SEG7_HEX_EN -> pattern_err.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan receiver.
// Holds the active-low segment pattern constants (bit order g..a, bit0 = a), the blank
// pattern, the FSM state type and the stability counter width.
// Optional feature macro: SEG7_HEX_EN (the A..F patterns are only consumed when it is set).
package seg7_pkg;

  // Wide enough for STABLE_CYCLES up to 15.
  localparam int unsigned CntW = 4;

  localparam logic [6:0] SegBlank = 7'b1111111;

  localparam logic [6:0] Seg0 = 7'b1000000;
  localparam logic [6:0] Seg1 = 7'b1111001;
  localparam logic [6:0] Seg2 = 7'b0100100;
  localparam logic [6:0] Seg3 = 7'b0110000;
  localparam logic [6:0] Seg4 = 7'b0011001;
  localparam logic [6:0] Seg5 = 7'b0010010;
  localparam logic [6:0] Seg6 = 7'b0000010;
  localparam logic [6:0] Seg7 = 7'b1111000;
  localparam logic [6:0] Seg8 = 7'b0000000;
  localparam logic [6:0] Seg9 = 7'b0010000;
  localparam logic [6:0] SegA = 7'b0001000;
  localparam logic [6:0] SegB = 7'b0000011;
  localparam logic [6:0] SegC = 7'b1000110;
  localparam logic [6:0] SegD = 7'b0100001;
  localparam logic [6:0] SegE = 7'b0000110;
  localparam logic [6:0] SegF = 7'b0001110;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StHeld
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern decoder.
// Ports:
//   pattern_i - active-low segment pattern, bit0 = a ... bit6 = g
//   legal_o   - pattern is a recognised digit
//   blank_o   - pattern is all segments off
//   value_o   - decoded digit value (0 when not legal)
// Macro SEG7_HEX_EN: when defined, the A..F patterns are legal and decode to 10..15.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] value_o
);

  always_comb begin
    legal_o = 1'b1;
    blank_o = 1'b0;
    value_o = 4'd0;
    case (pattern_i)
      Seg0:     value_o = 4'd0;
      Seg1:     value_o = 4'd1;
      Seg2:     value_o = 4'd2;
      Seg3:     value_o = 4'd3;
      Seg4:     value_o = 4'd4;
      Seg5:     value_o = 4'd5;
      Seg6:     value_o = 4'd6;
      Seg7:     value_o = 4'd7;
      Seg8:     value_o = 4'd8;
      Seg9:     value_o = 4'd9;
`ifdef SEG7_HEX_EN
      SegA:     value_o = 4'd10;
      SegB:     value_o = 4'd11;
      SegC:     value_o = 4'd12;
      SegD:     value_o = 4'd13;
      SegE:     value_o = 4'd14;
      SegF:     value_o = 4'd15;
`endif
      SegBlank: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default:  legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Receiver for a multiplexed seven-segment display scan. Samples the segment and digit-enable
// lines, waits for STABLE_CYCLES identical samples with exactly one digit enabled, then
// captures the decoded digit once into its slot.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   seg_n        - active-low segments, bit0 = a ... bit6 = g
//   dig_sel_n    - active-low digit enables, bit i selects digit i
//   bcd_out      - decoded value of digit i in bits [4i+3:4i]
//   digit_valid  - slot i holds a decode of a legal pattern
//   frame_done   - one-cycle pulse: last digit captured and every slot valid
//   pattern_err  - one-cycle pulse: an illegal (non-blank) pattern was captured
//   err_digit    - digit index of the most recent pattern_err
// Macro SEG7_HEX_EN (in seg7_pattern_decode): accept hex patterns A..F.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic [2:0]              err_digit
);

  seg7_state_e             state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [6:0]              seg_q, cand_seg_q, cand_seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, cand_sel_q, cand_sel_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    frame_q, frame_d;
  logic                    perr_q, perr_d;
  logic [2:0]              edig_q, edig_d;

  logic [NUM_DIGITS-1:0]   sel_act;
  logic                    sel_onehot;
  logic [2:0]              sel_idx;
  logic                    same;
  logic                    capture;
  logic                    dec_legal;
  logic                    dec_blank;
  logic [3:0]              dec_value;

  // Capture always happens while the sample equals the candidate, so decoding the sample
  // register is equivalent to decoding the candidate.
  seg7_pattern_decode u_dec (
    .pattern_i (seg_q),
    .legal_o   (dec_legal),
    .blank_o   (dec_blank),
    .value_o   (dec_value)
  );

  always_comb begin
    sel_act    = ~sel_q;
    sel_onehot = ($countones(sel_act) == 1);
    sel_idx    = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_act[i]) sel_idx = 3'(i);
    end
    same = (seg_q == cand_seg_q) && (sel_q == cand_sel_q);
  end

  // Stability FSM: count_q is the number of consecutive identical samples seen so far.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cand_seg_d = cand_seg_q;
    cand_sel_d = cand_sel_q;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_onehot) begin
          state_d    = StTrack;
          count_d    = CntW'(1);
          cand_seg_d = seg_q;
          cand_sel_d = sel_q;
        end
      end
      StTrack: begin
        if (!sel_onehot) begin
          state_d = StIdle;
          count_d = '0;
        end else if (same) begin
          count_d = count_q + CntW'(1);
          if (count_q == CntW'(STABLE_CYCLES - 1)) begin
            capture = 1'b1;
            state_d = StHeld;
          end
        end else begin
          count_d    = CntW'(1);
          cand_seg_d = seg_q;
          cand_sel_d = sel_q;
        end
      end
      StHeld: begin
        if (!sel_onehot) begin
          state_d = StIdle;
          count_d = '0;
        end else if (!same) begin
          state_d    = StTrack;
          count_d    = CntW'(1);
          cand_seg_d = seg_q;
          cand_sel_d = sel_q;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    perr_d  = 1'b0;
    edig_d  = edig_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && sel_act[i]) begin
        if (dec_legal) begin
          bcd_d[4*i +: 4] = dec_value;
          valid_d[i]      = 1'b1;
        end else begin
          valid_d[i] = 1'b0;
        end
      end
    end
    if (capture && !dec_legal && !dec_blank) begin
      perr_d = 1'b1;
      edig_d = sel_idx;
    end
    frame_d = capture && sel_act[NUM_DIGITS-1] && (&valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      seg_q      <= '1;
      sel_q      <= '1;
      cand_seg_q <= '1;
      cand_sel_q <= '1;
      bcd_q      <= '0;
      valid_q    <= '0;
      frame_q    <= 1'b0;
      perr_q     <= 1'b0;
      edig_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      seg_q      <= seg_n;
      sel_q      <= dig_sel_n;
      cand_seg_q <= cand_seg_d;
      cand_sel_q <= cand_sel_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      perr_q     <= perr_d;
      edig_q     <= edig_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign pattern_err = perr_q;
  assign err_digit   = edig_q;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Bench for seg7_scan_rx (NUM_DIGITS=4, STABLE_CYCLES=4). Works with or without SEG7_HEX_EN.
module tb_seg7_scan_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = 7'h7f;
  logic [3:0]  dig_sel_n = 4'hf;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        pattern_err;
  logic [2:0]  err_digit;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [2:0]  err_q[$];
  logic        frame_q[$];

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic [15:0] bcd;
    logic [3:0]  valid;
    bit          frame;
    bit          err;
    logic [2:0]  edig;
  } vec_t;

  vec_t vecs[15];

  seg7_scan_rx #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .pattern_err (pattern_err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_bcd"}, {16'd0, bcd_out}, 32'd0);
    chk({tag, "_valid"}, {28'd0, digit_valid}, 32'd0);
    chk({tag, "_frame"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_perr"}, {31'd0, pattern_err}, 32'd0);
    chk({tag, "_edig"}, {29'd0, err_digit}, 32'd0);
  endtask

  // Pulse scoreboard: every observed pulse cycle must match a queued expectation.
  always @(negedge clk) begin
    if (pattern_err === 1'b1) begin
      if (err_q.size() == 0) chk("pattern_err_unexpected", {31'd0, pattern_err}, 32'd0);
      else chk("err_digit", {29'd0, err_digit}, {29'd0, err_q.pop_front()});
    end
    if (frame_done === 1'b1) begin
      if (frame_q.size() == 0) chk("frame_done_unexpected", {31'd0, frame_done}, 32'd0);
      else chk("frame_done", {31'd0, frame_done}, {31'd0, frame_q.pop_front()});
    end
  end

  initial begin
    // Table: each vector held 6 cycles (capture becomes visible after the 5th).
    vecs[0]  = '{7'b0100100, 4'b1110, 16'h0002, 4'b0001, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{7'b1111001, 4'b1110, 16'h0001, 4'b0001, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{7'b0100100, 4'b1101, 16'h0021, 4'b0011, 1'b0, 1'b0, 3'd0};
    vecs[3]  = '{7'b0110000, 4'b1011, 16'h0321, 4'b0111, 1'b0, 1'b0, 3'd0};
    vecs[4]  = '{7'b0011001, 4'b0111, 16'h4321, 4'b1111, 1'b1, 1'b0, 3'd0};
    vecs[5]  = '{7'b0110110, 4'b1011, 16'h4321, 4'b1011, 1'b0, 1'b1, 3'd2};
    vecs[6]  = '{7'b0010010, 4'b0111, 16'h5321, 4'b1011, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{7'b0000010, 4'b1011, 16'h5621, 4'b1111, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{7'b1111000, 4'b0111, 16'h7621, 4'b1111, 1'b1, 1'b0, 3'd0};
    vecs[9]  = '{7'b0000000, 4'b1110, 16'h7628, 4'b1111, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{7'b0010000, 4'b1101, 16'h7698, 4'b1111, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{7'b1111111, 4'b1101, 16'h7698, 4'b1101, 1'b0, 1'b0, 3'd0};
`ifdef SEG7_HEX_EN
    vecs[12] = '{7'b0001000, 4'b0111, 16'hA698, 4'b1101, 1'b0, 1'b0, 3'd0};
    vecs[13] = '{7'b1000000, 4'b1101, 16'hA608, 4'b1111, 1'b0, 1'b0, 3'd0};
`else
    vecs[12] = '{7'b0001000, 4'b0111, 16'h7698, 4'b0101, 1'b0, 1'b1, 3'd3};
    vecs[13] = '{7'b1000000, 4'b1101, 16'h7608, 4'b0111, 1'b0, 1'b0, 3'd0};
`endif
    vecs[14] = '{7'b0110000, 4'b0111, 16'h3608, 4'b1111, 1'b1, 1'b0, 3'd0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // Exact latency: pins applied before edge k, capture on edge k+4.
    seg_n = 7'b0100100; dig_sel_n = 4'b1110;
    repeat (4) @(negedge clk);
    chk("latency_early_valid", {28'd0, digit_valid}, 32'h1 ^ 32'h1);
    @(negedge clk);
    chk("latency_valid", {28'd0, digit_valid}, 32'h1);
    chk("latency_slot0", {28'd0, bcd_out[3:0]}, 32'h2);

    // Glitch after three stable cycles: the first value is never captured.
    seg_n = 7'b0110000; dig_sel_n = 4'b1101;
    repeat (3) @(negedge clk);
    seg_n = 7'b0010010;
    repeat (4) @(negedge clk);
    chk("glitch_no_capture", {28'd0, digit_valid}, 32'h1);
    chk("glitch_slot1_old", {28'd0, bcd_out[7:4]}, 32'h0);
    @(negedge clk);
    chk("glitch_capture_valid", {28'd0, digit_valid}, 32'h3);
    chk("glitch_slot1", {28'd0, bcd_out[7:4]}, 32'h5);

    // Two digits enabled: never leaves IDLE.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seg_n = 7'b1111001; dig_sel_n = 4'b1001;
    repeat (10) @(negedge clk);
    chk("multisel_valid", {28'd0, digit_valid}, 32'h0);
    chk("multisel_bcd", {16'd0, bcd_out}, 32'h0);

    // Reset lands on what would have been the capture edge.
    dig_sel_n = 4'b1110;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midtrack_reset");

    rst = 1'b0;
    foreach (vecs[v]) begin
      seg_n     = vecs[v].seg;
      dig_sel_n = vecs[v].sel;
      if (vecs[v].frame) frame_q.push_back(1'b1);
      if (vecs[v].err) err_q.push_back(vecs[v].edig);
      repeat (6) @(negedge clk);
      chk($sformatf("vec%0d_bcd", v), {16'd0, bcd_out}, {16'd0, vecs[v].bcd});
      chk($sformatf("vec%0d_valid", v), {28'd0, digit_valid}, {28'd0, vecs[v].valid});
    end

    repeat (2) @(negedge clk);
    chk("frame_pulses_outstanding", frame_q.size(), 32'd0);
    chk("err_pulses_outstanding", err_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
